// File: rtl/decode_dispatch_queue.sv
// Decode-to-rename instruction buffer: up to two decoded instructions in and
// two in-order instructions out per cycle, with serialization of privileged/eret ops.
package decode_dispatch_queue_pkg;
  typedef struct packed {
    logic [31:0] raw;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  fu_type;
  } decoded_inst_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] tval;
  } exception_t;

  localparam logic [4:0] EXCCODE_RI = 5'd10;
endpackage

module decode_dispatch_queue
  import decode_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [1:0]            in_valid,
  input  decoded_inst_t [1:0]   in_inst,
  input  logic [1:0][31:0]      in_pc,
  input  exception_t [1:0]      in_exc,
  input  logic [1:0]            in_serialize,
  output logic                  in_ready,
  input  logic                  backend_empty,
  output logic [1:0]            out_valid,
  output decoded_inst_t [1:0]   out_inst,
  output logic [1:0][31:0]      out_pc,
  output exception_t [1:0]      out_exc,
  input  logic [1:0]            out_accept
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_NORMAL,
    S_DRAIN,
    S_SER_ISSUE,
    S_SER_WAIT
  } state_t;

  decoded_inst_t inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  exception_t    exc_mem  [DEPTH];
  logic          ser_mem  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q;
  logic             in_ready_q, in_ready_d;

  logic [1:0][PTR_W-1:0] rd_idx;
  logic [1:0][PTR_W-1:0] wr_idx;
  logic [1:0]            rd_special;
  logic [1:0]            acc;
  logic                  enq_fire;
  logic [CNT_W-1:0]      enq_n;
  logic [CNT_W-1:0]      deq_n;

  // Slot gi reads head+gi and writes tail+gi; the carry out of the pointer is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign rd_idx[gi]     = head_q + PTR_W'(gi);
      assign wr_idx[gi]     = tail_q + PTR_W'(gi);
      assign rd_special[gi] = ser_mem[rd_idx[gi]] | exc_mem[rd_idx[gi]].ex;
      assign out_inst[gi]   = inst_mem[rd_idx[gi]];
      assign out_pc[gi]     = pc_mem[rd_idx[gi]];
      assign out_exc[gi]    = exc_mem[rd_idx[gi]];
    end
  endgenerate

  always_comb begin
    out_valid = 2'b00;
    case (state_q)
      S_NORMAL: begin
        if (count_q != '0 && !ser_mem[head_q]) begin
          out_valid[0] = 1'b1;
          out_valid[1] = (count_q >= CNT_W'(2)) && !rd_special[0] && !rd_special[1];
        end
      end
      S_SER_ISSUE: out_valid[0] = (count_q != '0);
      default: out_valid = 2'b00;
    endcase
  end

  assign in_ready = in_ready_q;
  assign acc      = out_accept & out_valid;
  assign enq_fire = in_ready_q && !flush && in_valid[0];
  assign enq_n    = enq_fire ? (in_valid[1] ? CNT_W'(2) : CNT_W'(1)) : '0;
  assign deq_n    = flush ? '0 : (CNT_W'(acc[0]) + CNT_W'(acc[1]));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + enq_n - deq_n;
    end
    in_ready_d = (count_d <= CNT_W'(DEPTH - 2));
  end

  // Pointers, occupancy and the serialization FSM; flush overrides everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      state_q    <= S_NORMAL;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      if (flush) begin
        state_q <= S_NORMAL;
      end else begin
        case (state_q)
          S_NORMAL:    if (count_q != '0 && ser_mem[head_q]) state_q <= S_DRAIN;
          S_DRAIN:     if (backend_empty) state_q <= S_SER_ISSUE;
          S_SER_ISSUE: if (acc[0]) state_q <= S_SER_WAIT;
          S_SER_WAIT:  if (backend_empty) state_q <= S_NORMAL;
          default:     state_q <= S_NORMAL;
        endcase
      end
    end
  end

  // Entry storage carries no reset; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i]) begin
          inst_mem[wr_idx[i]] <= in_inst[i];
          pc_mem[wr_idx[i]]   <= in_pc[i];
          exc_mem[wr_idx[i]]  <= in_exc[i];
          ser_mem[wr_idx[i]]  <= in_serialize[i];
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_enq_needs_ready: assert property (@(posedge clk) disable iff (!resetn)
    (!flush && in_valid != 2'b00) |-> in_ready_q);

  a_in_valid_thermo: assert property (@(posedge clk) disable iff (!resetn)
    in_valid != 2'b10);

  a_accept_thermo: assert property (@(posedge clk) disable iff (!resetn)
    out_accept != 2'b10);

  a_accept_subset: assert property (@(posedge clk) disable iff (!resetn)
    !flush |-> ((out_accept & ~out_valid) == 2'b00));

  a_count_range: assert property (@(posedge clk) disable iff (!resetn)
    count_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Scoreboard bench for decode_dispatch_queue: entries are queued when driven
// and compared against the dispatch slots when rename is expected to see them.
`timescale 1ns/1ps
module tb_decode_dispatch_queue;
  import decode_dispatch_queue_pkg::*;

  localparam int DEPTH = 8;

  typedef struct packed {
    decoded_inst_t inst;
    exception_t    exc;
    logic [31:0]   pc;
    logic          ser;
  } entry_t;

  logic                clk = 1'b0;
  logic                resetn;
  logic                flush;
  logic [1:0]          in_valid;
  decoded_inst_t [1:0] in_inst;
  logic [1:0][31:0]    in_pc;
  exception_t [1:0]    in_exc;
  logic [1:0]          in_serialize;
  logic                in_ready;
  logic                backend_empty;
  logic [1:0]          out_valid;
  decoded_inst_t [1:0] out_inst;
  logic [1:0][31:0]    out_pc;
  exception_t [1:0]    out_exc;
  logic [1:0]          out_accept;

  int     checks = 0;
  int     errors = 0;
  entry_t exp_q[$];
  entry_t nop_e = '0;

  always #5 clk = ~clk;

  decode_dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_inst       (in_inst),
    .in_pc         (in_pc),
    .in_exc        (in_exc),
    .in_serialize  (in_serialize),
    .in_ready      (in_ready),
    .backend_empty (backend_empty),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_exc       (out_exc),
    .out_accept    (out_accept)
  );

  function automatic entry_t mk(input logic [31:0] pc, input logic ser, input logic ex);
    entry_t e;
    e.pc            = pc;
    e.ser           = ser;
    e.inst.raw      = {pc[15:0], 16'h0033} ^ 32'h5a5a_0000;
    e.inst.opcode   = ser ? 7'h73 : 7'h33;
    e.inst.rd       = pc[6:2];
    e.inst.rs1      = pc[7:3];
    e.inst.rs2      = pc[8:4];
    e.inst.fu_type  = pc[5:2];
    e.exc.ex        = ex;
    e.exc.exccode   = ex ? EXCCODE_RI : 5'd0;
    e.exc.tval      = ex ? pc : 32'h0;
    return e;
  endfunction

  // Drives one cycle of inputs and updates the scoreboard to match.
  task automatic drive(input logic [1:0] v, input entry_t e0, input entry_t e1,
                       input logic [1:0] acc, input logic be, input logic fl);
    in_valid      = v;
    in_inst[0]    = e0.inst;
    in_inst[1]    = e1.inst;
    in_pc[0]      = e0.pc;
    in_pc[1]      = e1.pc;
    in_exc[0]     = e0.exc;
    in_exc[1]     = e1.exc;
    in_serialize  = {e1.ser, e0.ser};
    out_accept    = acc;
    backend_empty = be;
    flush         = fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (acc[0]) void'(exp_q.pop_front());
      if (acc[1]) void'(exp_q.pop_front());
      if (v[0]) exp_q.push_back(e0);
      if (v[1]) exp_q.push_back(e1);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(2'b00, nop_e, nop_e, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 00", out_valid);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL idle_out_valid: got %b expected 00", out_valid);
    end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_fill();
    logic       exp_rdy;
    logic [1:0] exp_v;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_rdy = (i < 4);
      exp_v   = (i == 0) ? 2'b00 : 2'b11;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL fill_ready cyc%0d: got %b expected %b", i, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL fill_valid cyc%0d: got %b expected %b", i, out_valid, exp_v);
      end
      if (i > 0) begin
        for (int s = 0; s < 2; s++) begin
          checks++;
          if ({out_inst[s], out_exc[s], out_pc[s]} !== {exp_q[s].inst, exp_q[s].exc, exp_q[s].pc}) begin
            errors++;
            $display("FAIL fill_slot%0d cyc%0d: got pc=%h inst=%h exc=%h expected pc=%h inst=%h exc=%h",
                     s, i, out_pc[s], out_inst[s], out_exc[s], exp_q[s].pc, exp_q[s].inst, exp_q[s].exc);
          end
        end
      end
      // The fifth pair (0x1020/0x1024) is held back while in_ready is low.
      if (i < 4)
        drive(2'b11, mk(32'h1000 + 32'(8 * i), 1'b0, 1'b0),
              mk(32'h1004 + 32'(8 * i), 1'b0, 1'b0), 2'b00, 1'b0, 1'b0);
      else
        drive(2'b00, nop_e, nop_e, 2'b00, 1'b0, 1'b0);
      $display("fill cyc%0d: in_ready=%b out_valid=%b head_pc=%h", i, in_ready, out_valid, out_pc[0]);
    end
  endtask

  task automatic test_stream();
    logic [31:0] npc = 32'h1020;
    logic        exp_rdy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL stream_ready cyc%0d: got %b expected %b", c, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== 2'b11) begin
        errors++; $display("FAIL stream_valid cyc%0d: got %b expected 11", c, out_valid);
      end
      for (int s = 0; s < 2; s++) begin
        checks++;
        if ({out_inst[s], out_exc[s], out_pc[s]} !== {exp_q[s].inst, exp_q[s].exc, exp_q[s].pc}) begin
          errors++;
          $display("FAIL stream_slot%0d cyc%0d: got pc=%h inst=%h exc=%h expected pc=%h inst=%h exc=%h",
                   s, c, out_pc[s], out_inst[s], out_exc[s], exp_q[s].pc, exp_q[s].inst, exp_q[s].exc);
        end
      end
      $display("stream cyc%0d: out_pc=%h,%h in_ready=%b", c, out_pc[0], out_pc[1], in_ready);
      if (exp_rdy) begin
        drive(2'b11, mk(npc, 1'b0, 1'b0), mk(npc + 32'd4, 1'b0, 1'b0), 2'b11, 1'b0, 1'b0);
        npc = npc + 32'd8;
      end else begin
        drive(2'b00, nop_e, nop_e, 2'b11, 1'b0, 1'b0);
      end
      exp_rdy = ((DEPTH - exp_q.size()) >= 2);
    end
  endtask

  task automatic test_serialize();
    logic [1:0] ev [9];
    logic       be [9];
    logic [1:0] ac [9];
    ev = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    be = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ac = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    @(negedge clk);
    drive(2'b00, nop_e, nop_e, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    drive(2'b11, mk(32'h2000, 1'b1, 1'b0), mk(32'h2004, 1'b0, 1'b0), 2'b00, 1'b0, 1'b0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== ev[c]) begin
        errors++; $display("FAIL ser_valid cyc%0d: got %b expected %b", c, out_valid, ev[c]);
      end
      if (ev[c][0]) begin
        checks++;
        if ({out_inst[0], out_exc[0], out_pc[0]} !== {exp_q[0].inst, exp_q[0].exc, exp_q[0].pc}) begin
          errors++;
          $display("FAIL ser_slot0 cyc%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                   c, out_pc[0], out_inst[0], exp_q[0].pc, exp_q[0].inst);
        end
      end
      $display("serialize cyc%0d: backend_empty=%b out_valid=%b head_pc=%h", c, be[c], out_valid, out_pc[0]);
      drive(2'b00, nop_e, nop_e, ac[c], be[c], 1'b0);
    end
  endtask

  task automatic test_exception();
    logic [1:0] ev [4];
    logic [1:0] ac [4];
    ev = '{2'b01, 2'b01, 2'b11, 2'b00};
    ac = '{2'b01, 2'b01, 2'b11, 2'b00};
    @(negedge clk);
    drive(2'b00, nop_e, nop_e, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    drive(2'b11, mk(32'h3000, 1'b0, 1'b0), mk(32'h3004, 1'b0, 1'b1), 2'b00, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== ev[c]) begin
        errors++; $display("FAIL exc_valid cyc%0d: got %b expected %b", c, out_valid, ev[c]);
      end
      for (int s = 0; s < 2; s++) begin
        if (ev[c][s]) begin
          checks++;
          if ({out_inst[s], out_exc[s], out_pc[s]} !== {exp_q[s].inst, exp_q[s].exc, exp_q[s].pc}) begin
            errors++;
            $display("FAIL exc_slot%0d cyc%0d: got pc=%h exc=%h expected pc=%h exc=%h",
                     s, c, out_pc[s], out_exc[s], exp_q[s].pc, exp_q[s].exc);
          end
        end
      end
      $display("exception cyc%0d: out_valid=%b head_pc=%h head_ex=%b", c, out_valid, out_pc[0], out_exc[0].ex);
      if (c == 0)
        drive(2'b11, mk(32'h3008, 1'b0, 1'b0), mk(32'h300c, 1'b0, 1'b0), ac[c], 1'b1, 1'b0);
      else
        drive(2'b00, nop_e, nop_e, ac[c], 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush_drain();
    @(negedge clk);
    drive(2'b00, nop_e, nop_e, 2'b00, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      drive(2'b11, mk(32'h4000 + 32'(8 * p), (p == 0), 1'b0),
            mk(32'h4004 + 32'(8 * p), 1'b0, 1'b0), 2'b00, 1'b0, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL drain_valid: got %b expected 00", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL drain_ready6: got %b expected 1", in_ready);
    end
    drive(2'b11, mk(32'h5000, 1'b0, 1'b0), mk(32'h5004, 1'b0, 1'b0), 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL flush_valid: got %b expected 00", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready: got %b expected 1", in_ready);
    end
    $display("flush: out_valid=%b in_ready=%b", out_valid, in_ready);
    drive(2'b01, mk(32'h6000, 1'b0, 1'b0), nop_e, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 2'b01) begin
      errors++; $display("FAIL post_flush_valid: got %b expected 01", out_valid);
    end
    checks++;
    if ({out_inst[0], out_exc[0], out_pc[0]} !== {exp_q[0].inst, exp_q[0].exc, exp_q[0].pc}) begin
      errors++;
      $display("FAIL post_flush_slot0: got pc=%h expected pc=%h", out_pc[0], exp_q[0].pc);
    end
    $display("post-flush: out_valid=%b head_pc=%h", out_valid, out_pc[0]);
    drive(2'b00, nop_e, nop_e, 2'b01, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL post_flush_empty: got %b expected 00", out_valid);
    end
    drive(2'b00, nop_e, nop_e, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(2'b00, nop_e, nop_e, 2'b00, 1'b1, 1'b1);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      drive(2'b11, mk(32'h7000 + 32'(8 * p), 1'b0, 1'b0),
            mk(32'h7004 + 32'(8 * p), 1'b0, 1'b0), 2'b00, 1'b1, 1'b0);
    end
    @(negedge clk);
    drive(2'b00, nop_e, nop_e, 2'b00, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 2'b11) begin
      errors++; $display("FAIL pre_reset_full: got ready=%b valid=%b expected ready=0 valid=11", in_ready, out_valid);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL async_reset_valid: got %b expected 00", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset_ready: got %b expected 1", in_ready);
    end
    $display("async reset: out_valid=%b in_ready=%b", out_valid, in_ready);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    drive(2'b01, mk(32'h8000, 1'b0, 1'b0), nop_e, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 2'b01 || out_pc[0] !== exp_q[0].pc) begin
      errors++; $display("FAIL post_reset_enq: got valid=%b pc=%h expected valid=01 pc=%h", out_valid, out_pc[0], exp_q[0].pc);
    end
    $display("post-reset: out_valid=%b head_pc=%h", out_valid, out_pc[0]);
    drive(2'b00, nop_e, nop_e, 2'b01, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'b00, nop_e, nop_e, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_serialize();
    test_exception();
    test_flush_drain();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
